// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared types and response codes for the AXI-Lite command master.
package axi_lite_cmd_master_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrAddr = 3'd1,
    StWaitB  = 3'd2,
    StRdAddr = 3'd3,
    StWaitR  = 3'd4,
    StRsp    = 3'd5
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AW/W/B or AR/R
// transaction and returns a registered response, with a response-wait timeout.
module axi_lite_cmd_master
  import axi_lite_cmd_master_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            axi_aclk,
  input  logic                            axi_areset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam logic [31:0] CntLast = 32'(C_TIMEOUT_CYCLES - 1);

  state_e                            r_state, w_state_nxt;
  logic                              r_cmd_ready, w_cmd_ready_nxt;
  logic                              r_bready, w_bready_nxt;
  logic                              r_rready, w_rready_nxt;
  logic                              r_awvalid, w_awvalid_nxt;
  logic                              r_wvalid, w_wvalid_nxt;
  logic                              r_arvalid, w_arvalid_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     r_addr, w_addr_nxt;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata, w_wdata_nxt;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wstrb, w_wstrb_nxt;
  logic [31:0]                       r_cnt, w_cnt_nxt;
  logic                              r_rsp_valid, w_rsp_valid_nxt;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]                        r_rsp_resp, w_rsp_resp_nxt;
  logic                              r_rsp_timeout, w_rsp_timeout_nxt;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_state       <= StIdle;
      r_cmd_ready   <= 1'b0;
      r_bready      <= 1'b0;
      r_rready      <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_cnt         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= RespOkay;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_bready      <= w_bready_nxt;
      r_rready      <= w_rready_nxt;
      r_awvalid     <= w_awvalid_nxt;
      r_wvalid      <= w_wvalid_nxt;
      r_arvalid     <= w_arvalid_nxt;
      r_addr        <= w_addr_nxt;
      r_wdata       <= w_wdata_nxt;
      r_wstrb       <= w_wstrb_nxt;
      r_cnt         <= w_cnt_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_resp    <= w_rsp_resp_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_awvalid_nxt     = r_awvalid;
    w_wvalid_nxt      = r_wvalid;
    w_arvalid_nxt     = r_arvalid;
    w_addr_nxt        = r_addr;
    w_wdata_nxt       = r_wdata;
    w_wstrb_nxt       = r_wstrb;
    w_cnt_nxt         = r_cnt;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_resp_nxt    = r_rsp_resp;
    w_rsp_timeout_nxt = r_rsp_timeout;

    unique case (r_state)
      StIdle: begin
        if (cmd_valid && r_cmd_ready) begin
          w_addr_nxt  = cmd_addr;
          w_wdata_nxt = cmd_wdata;
          w_wstrb_nxt = cmd_wstrb;
          if (cmd_wr) begin
            w_state_nxt   = StWrAddr;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = StRdAddr;
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      StWrAddr: begin
        // AW and W complete independently; move on once neither is pending.
        if (m_axi_awready) w_awvalid_nxt = 1'b0;
        if (m_axi_wready)  w_wvalid_nxt  = 1'b0;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_state_nxt = StWaitB;
          w_cnt_nxt   = '0;
        end
      end
      StWaitB: begin
        if (m_axi_bvalid && r_bready) begin
          w_state_nxt       = StRsp;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = '0;
          w_rsp_resp_nxt    = m_axi_bresp;
          w_rsp_timeout_nxt = 1'b0;
        end else if (r_cnt == CntLast) begin
          w_state_nxt       = StRsp;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = '0;
          w_rsp_resp_nxt    = RespSlverr;
          w_rsp_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      StRdAddr: begin
        if (m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_state_nxt   = StWaitR;
          w_cnt_nxt     = '0;
        end
      end
      StWaitR: begin
        if (m_axi_rvalid && r_rready) begin
          w_state_nxt       = StRsp;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = m_axi_rdata;
          w_rsp_resp_nxt    = m_axi_rresp;
          w_rsp_timeout_nxt = 1'b0;
        end else if (r_cnt == CntLast) begin
          w_state_nxt       = StRsp;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = '0;
          w_rsp_resp_nxt    = RespSlverr;
          w_rsp_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          w_state_nxt     = StIdle;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // Ready outputs are registered copies of the next state's decode.
    w_cmd_ready_nxt = (w_state_nxt == StIdle);
    w_bready_nxt    = (w_state_nxt == StIdle) || (w_state_nxt == StWaitB);
    w_rready_nxt    = (w_state_nxt == StIdle) || (w_state_nxt == StWaitR);
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_timeout   = r_rsp_timeout;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: a transaction table driven through a
// small slave model, plus sequences for timeout timing, backpressure and reset.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_TIMEOUT_CYCLES  (16)
  ) dut (
    .axi_aclk     (clk),
    .axi_areset   (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          a_dly;     // cycles of valid before AW/AR ready
    int          w_dly;     // cycles of wvalid before wready
    int          r_dly;     // cycles in wait state before B/R valid (255 = never)
    logic [1:0]  sresp;
    logic [31:0] srdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_to;
  } txn_t;

  txn_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_slave();
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = 32'h0;
    m_axi_rresp   = 2'b00;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    clear_slave();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input txn_t t);
    int aw_w = 0, w_w = 0, ar_w = 0, b_w = 0, r_w = 0;
    int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0;
    logic b_pend = 0, r_pend = 0, got = 0;
    logic hs_cmd, hs_aw, hs_w, hs_ar, hs_b, hs_r, aw_pre, w_pre, ar_pre;
    logic [31:0] g_rdata = '0;
    logic [1:0]  g_resp = '0;
    logic        g_to = 0;
    cmd_valid = 1'b1;
    cmd_wr    = t.wr;
    cmd_addr  = t.addr;
    cmd_wdata = t.wdata;
    cmd_wstrb = t.wstrb;
    rsp_ready = 1'b1;
    for (int c = 0; c < 100 && !got; c++) begin
      m_axi_awready = m_axi_awvalid && (aw_w >= t.a_dly);
      m_axi_wready  = m_axi_wvalid && (w_w >= t.w_dly);
      m_axi_arready = m_axi_arvalid && (ar_w >= t.a_dly);
      m_axi_bvalid  = b_pend && (b_w >= t.r_dly);
      m_axi_bresp   = t.sresp;
      m_axi_rvalid  = r_pend && (r_w >= t.r_dly);
      m_axi_rdata   = t.srdata;
      m_axi_rresp   = t.sresp;
      hs_cmd = cmd_valid && cmd_ready;
      hs_aw  = m_axi_awvalid && m_axi_awready;
      hs_w   = m_axi_wvalid && m_axi_wready;
      hs_ar  = m_axi_arvalid && m_axi_arready;
      hs_b   = m_axi_bvalid && m_axi_bready;
      hs_r   = m_axi_rvalid && m_axi_rready;
      aw_pre = m_axi_awvalid;
      w_pre  = m_axi_wvalid;
      ar_pre = m_axi_arvalid;
      if (hs_aw) check("awaddr", m_axi_awaddr, t.addr);
      if (hs_w) begin
        check("wdata", m_axi_wdata, t.wdata);
        check("wstrb", m_axi_wstrb, t.wstrb);
      end
      if (hs_ar) check("araddr", m_axi_araddr, t.addr);
      step();
      if (hs_cmd) begin
        cmd_valid = 1'b0;
        check("cmd_to_valid_lat", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid},
              t.wr ? 3'b110 : 3'b001);
      end
      if (hs_aw) aw_n++; else if (aw_pre) aw_w++;
      if (hs_w) w_n++; else if (w_pre) w_w++;
      if (hs_ar) ar_n++; else if (ar_pre) ar_w++;
      if (hs_b) begin b_n++; b_pend = 0; end else if (b_pend) b_w++;
      if (hs_r) begin r_n++; r_pend = 0; end else if (r_pend) r_w++;
      if ((hs_aw || hs_w) && aw_n >= 1 && w_n >= 1) begin b_pend = 1; b_w = 0; end
      if (hs_ar) begin r_pend = 1; r_w = 0; end
      if (hs_b || hs_r) check("beat_to_rsp_lat", rsp_valid, 1'b1);
      if (rsp_valid) begin
        got     = 1;
        g_rdata = rsp_rdata;
        g_resp  = rsp_resp;
        g_to    = rsp_timeout;
      end
    end
    clear_slave();
    check("rsp_seen", got, 1'b1);
    check("rsp_rdata", g_rdata, t.exp_rdata);
    check("rsp_resp", g_resp, t.exp_resp);
    check("rsp_timeout", g_to, t.exp_to);
    check("aw_beats", aw_n, t.wr ? 1 : 0);
    check("w_beats", w_n, t.wr ? 1 : 0);
    check("ar_beats", ar_n, t.wr ? 0 : 1);
    check("b_beats", b_n, (t.wr && !t.exp_to) ? 1 : 0);
    check("r_beats", r_n, (!t.wr && !t.exp_to) ? 1 : 0);
    step();
    check("post_rsp_idle", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        done, seen, stab, hs_cmd, hs_ar;
    int          n;
    tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 3, 2'b00, 32'h0,
               32'h0, 2'b00, 1'b0};
    tbl[1] = '{1'b1, 32'h20, 32'hCAFEF00D, 4'h3, 0, 5, 0, 2'b00, 32'h0,
               32'h0, 2'b00, 1'b0};
    tbl[2] = '{1'b1, 32'h24, 32'h00000001, 4'h8, 4, 1, 1, 2'b10, 32'h0,
               32'h0, 2'b10, 1'b0};
    tbl[3] = '{1'b0, 32'h14, 32'h0, 4'h0, 0, 0, 2, 2'b10, 32'h12345678,
               32'h12345678, 2'b10, 1'b0};
    tbl[4] = '{1'b0, 32'h18, 32'h0, 4'h0, 3, 0, 0, 2'b00, 32'hA5A5A5A5,
               32'hA5A5A5A5, 2'b00, 1'b0};
    tbl[5] = '{1'b1, 32'h28, 32'h55AA55AA, 4'hF, 0, 0, 255, 2'b00, 32'h0,
               32'h0, 2'b10, 1'b1};
    tbl[6] = '{1'b0, 32'h2C, 32'h0, 4'h0, 1, 0, 255, 2'b00, 32'hFFFFFFFF,
               32'h0, 2'b10, 1'b1};
    // R lands on the expiry cycle: the handshake must win over the timeout.
    tbl[7] = '{1'b0, 32'h30, 32'h0, 4'h0, 0, 0, 15, 2'b00, 32'h0BADF00D,
               32'h0BADF00D, 2'b00, 1'b0};

    cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    clear_slave();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid, rsp_rdata,
                         rsp_resp, rsp_timeout, m_axi_awaddr, m_axi_wstrb}, '0);
    rst = 1'b0;
    step();
    check("ready_after_reset", {cmd_ready, m_axi_bready, m_axi_rready}, 3'b111);

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Read timeout timing, then a stray R beat in idle must be swallowed.
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h40; rsp_ready = 1'b0;
    m_axi_arready = 1'b1;
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      hs_cmd = cmd_valid && cmd_ready;
      hs_ar  = m_axi_arvalid && m_axi_arready;
      step();
      if (hs_cmd) cmd_valid = 1'b0;
      if (hs_ar) done = 1;
    end
    m_axi_arready = 1'b0;
    check("to_ar_handshake", done, 1'b1);
    n = 0;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    check("to_latency", n, 16);
    check("to_fields", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 2'b10, 32'h0});
    rsp_ready = 1'b1;
    step();
    check("to_rsp_done", {rsp_valid, m_axi_rready}, 2'b01);
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hBEEFBEEF;
    step();
    m_axi_rvalid = 1'b0;
    seen = rsp_valid;
    for (int c = 0; c < 5; c++) begin
      step();
      seen = seen | rsp_valid | !cmd_ready;
    end
    check("stray_r_swallowed", seen, 1'b0);

    // Response backpressure: outputs hold and a new command waits.
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h1; cmd_wstrb = 4'h1;
    rsp_ready = 1'b0; m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bresp = 2'b11;
    done = 0;
    for (int c = 0; c < 20 && !rsp_valid; c++) begin
      hs_cmd = cmd_valid && cmd_ready;
      m_axi_bvalid = done;
      step();
      if (hs_cmd) cmd_valid = 1'b0;
      if (!cmd_valid && !m_axi_awvalid && !m_axi_wvalid) done = 1;
    end
    clear_slave();
    check("bp_rsp", {rsp_valid, rsp_resp, rsp_timeout, rsp_rdata}, {1'b1, 2'b11, 1'b0, 32'h0});
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h54;
    stab = 1;
    for (int c = 0; c < 10; c++) begin
      step();
      stab = stab && rsp_valid && (rsp_resp == 2'b11) && (rsp_rdata == 32'h0) &&
             !rsp_timeout && !cmd_ready && !m_axi_arvalid;
    end
    check("bp_stable", stab, 1'b1);
    rsp_ready = 1'b1;
    step();
    check("bp_release", {rsp_valid, cmd_ready, m_axi_arvalid}, 3'b010);
    step();
    cmd_valid = 1'b0;
    check("bp_cmd_accepted", {cmd_ready, m_axi_arvalid, m_axi_araddr}, {2'b01, 32'h54});
    do_reset();

    // Reset while AW is stalled: no response may follow.
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h60; cmd_wdata = 32'h2; cmd_wstrb = 4'hF;
    rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    check("rst_pre_aw", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("rst_async", {m_axi_awvalid, m_axi_wvalid, rsp_valid}, 3'b000);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("rst_release", {cmd_ready, m_axi_bready, m_axi_rready}, 3'b111);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      seen = seen | rsp_valid | m_axi_awvalid | m_axi_wvalid;
    end
    check("rst_no_rsp", seen, 1'b0);

    run_txn(tbl[3]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_cmd_master.md
AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 32, is the AXI-Lite address width.
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 32, is the AXI-Lite data width; wstrb width is C_M_AXI_DATA_WIDTH/8.
REQ-003 Parameter C_TIMEOUT_CYCLES, default 1024, is the response-wait limit in clocks (minimum 2).
REQ-004 Ports, in order:
- axi_aclk  in  1  single clock.
- axi_areset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_wr  in  1  1=write, 0=read.
- cmd_addr  in  ADDR  target address.
- cmd_wdata  in  DATA  write data.
- cmd_wstrb  in  DATA/8  write strobes.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed.
- rsp_rdata  out  DATA  read data (0 for writes).
- rsp_resp  out  2  AXI response code.
- rsp_timeout  out  1  response wait expired.
- m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master channels at ADDR/DATA widths.

Function
REQ-005 States: IDLE, WR_ADDR, WAIT_B, RD_ADDR, WAIT_R, RSP; exactly one transaction outstanding at any time.
REQ-006 cmd_ready is high only in IDLE; a handshake on cycle N latches addr/wdata/wstrb/wr and moves the FSM to WR_ADDR (wr=1) or RD_ADDR (wr=0) at N+1.
REQ-007 In WR_ADDR, awvalid and wvalid both assert at N+1; each deasserts independently the cycle after its own ready handshake; the FSM enters WAIT_B once both handshakes are complete, including when both occur on the same cycle.
REQ-008 In RD_ADDR, arvalid asserts at N+1 and the FSM enters WAIT_R after the arready handshake.
REQ-009 Valid signals are never withdrawn before their handshake; no timeout applies in WR_ADDR or RD_ADDR.
REQ-010 bready is high in WAIT_B and IDLE; rready is high in WAIT_R and IDLE; B/R beats arriving in IDLE are accepted and discarded.
REQ-011 A B handshake in WAIT_B latches bresp, sets rsp_rdata=0 and rsp_timeout=0, and enters RSP.
REQ-012 An R handshake in WAIT_R latches rdata and rresp, sets rsp_timeout=0, and enters RSP.
REQ-013 A 32-bit timeout counter clears on entry to WAIT_B/WAIT_R and increments each cycle there; when it reaches C_TIMEOUT_CYCLES-1 without a handshake, the FSM enters RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-014 A handshake on the expiry cycle takes priority over the timeout.
REQ-015 rsp_valid is high only in RSP; rsp_* are stable while rsp_valid=1 and rsp_ready=0; a rsp handshake returns the FSM to IDLE, so cmd_ready is high on the next cycle.
REQ-016 All outputs are registered; command-accept to first address-channel valid latency is 1 cycle, and B/R handshake to rsp_valid latency is 1 cycle.
REQ-017 Unused address channels are driven with valid=0; address/data outputs hold the last latched values.

Reset
REQ-018 When axi_areset=1, the FSM goes to IDLE immediately and all valids, rsp_*, the counter and the latched registers go to 0; cmd_ready=1, bready=1 and rready=1 on the first clock edge after deassertion.
REQ-019 Reset mid-transaction abandons the transaction without emitting a response.

Structure
REQ-020 A shared package holds the state enumeration and the response constants OKAY=2'b00 and SLVERR=2'b10.
REQ-021 The block is a single flat module with no sub-modules; the timeout counter is inline.

Verification
REQ-022 Write addr=0x10, data=0xDEADBEEF, wstrb=0xF; awready and wready both on the first cycle; bresp=0 after 3 cycles -> one AW and one W beat, then rsp_valid with rsp_resp=0, rsp_rdata=0, rsp_timeout=0.
REQ-023 Write with wready 5 cycles after awready -> awvalid drops after its handshake, wvalid holds until its handshake, exactly one B accepted, then a single response.
REQ-024 Read addr=0x14; slave returns rdata=0x12345678, rresp=2'b10 -> rsp_rdata=0x12345678, rsp_resp=2'b10.
REQ-025 Read with rvalid never asserted, C_TIMEOUT_CYCLES=16 -> rsp_timeout=1 and rsp_resp=2'b10 exactly 16 cycles after the arready handshake; a later stray R in IDLE is swallowed with no second rsp_valid.
REQ-026 rsp_ready held low for 10 cycles -> rsp_* stable and cmd_ready low throughout; a command offered meanwhile is accepted only after the rsp handshake.
REQ-027 Assert axi_areset while awvalid=1 and awready=0 -> awvalid and rsp_valid low immediately, cmd_ready=1 after release, and no response is emitted.
